multicast_tx: RTL and testbench

- Transmit end of the PE multicast bus. Buffers {tag, value} words written by the host or global buffer and drives them onto the shared bus with an Enable/Ready handshake.
- Each PE-side receiver compares the tag against its latched ID and accepts the word when its own Ready is high.
- One instance per bus: weight, ifmap or psum.

---
 rtl/multicast_pkg.sv | 18 +
 rtl/mc_sync_fifo.sv | 74 +++++++
 rtl/multicast_tx.sv | 138 +++++++++++++
 tb/tb_multicast_tx.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/multicast_pkg.sv
// Shared definitions for the PE multicast bus (transmit and receive sides).
package multicast_pkg;

  localparam int MC_TAG_W  = 6;
  localparam int MC_DATA_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_t;

  // Bus word as seen by the receivers; the tag sits above the value.
  typedef struct packed {
    logic [MC_TAG_W-1:0]  tag;
    logic [MC_DATA_W-1:0] value;
  } mc_word_t;

endpackage

// File: rtl/mc_sync_fifo.sv
// Single-clock FIFO with registered read data (valid the cycle after pop).
// The read register can be cleared on its own so it can double as a bus
// output register that reads zero when nothing is being presented.
module mc_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 38,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic [W-1:0]  wr_data,
  input  logic          pop,
  input  logic          rd_clr,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_en;
  logic          rd_en;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // A push into a full FIFO still lands when the head leaves at the same edge.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  // Storage array; no reset needed since count gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Pointers and occupancy; pointers wrap naturally at power-of-two depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Registered head word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (clr || rd_clr) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_ptr];
    end
  end

endmodule

// File: rtl/multicast_tx.sv
// Transmit end of the PE multicast bus: buffers {tag, value} words and
// drives them onto the bus with an Enable/Ready handshake.
// Optional statistics counters: define MULTICAST_TX_STATS_EN.
//
//   state | meaning
//   IDLE  | nothing presented; Enable, tag and value read 0
//   SEND  | word presented; held until Ready_from_Bus accepts it
module multicast_tx
  import multicast_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = MC_TAG_W,
  parameter int DATA_W = MC_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_from_Host,
  input  logic [TAG_W-1:0]  Tag_from_Host,
  input  logic [DATA_W-1:0] value_from_Host,
  input  logic              flush_from_Host,
  output logic              full_to_Host,
  output logic              overflow_to_Host,
  output logic              busy_to_Host,
`ifdef MULTICAST_TX_STATS_EN
  output logic [31:0]       sent_cnt_to_Host,
  output logic [31:0]       stall_cnt_to_Host,
`endif
  input  logic              Ready_from_Bus,
  output logic              Enable_to_Bus,
  output logic [TAG_W-1:0]  Tag_to_Bus,
  output logic [DATA_W-1:0] value_to_Bus
);

  localparam int W  = TAG_W + DATA_W;
  localparam int AW = $clog2(DEPTH);

  tx_state_t      state;
  tx_state_t      state_nxt;
  logic           fire;
  logic           fifo_pop;
  logic           fifo_rd_clr;
  logic           fifo_empty;
  logic           fifo_full;
  logic [AW:0]    fifo_count;
  logic [W-1:0]   out_word;

  // The FIFO's registered read port is the output word register: popping
  // the head loads it at the same edge the FSM enters or stays in SEND.
  mc_sync_fifo #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (flush_from_Host),
    .push    (push_from_Host && !flush_from_Host),
    .wr_data ({Tag_from_Host, value_from_Host}),
    .pop     (fifo_pop),
    .rd_clr  (fifo_rd_clr),
    .rd_data (out_word),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign Enable_to_Bus = (state == SEND);
  assign Tag_to_Bus    = out_word[DATA_W +: TAG_W];
  assign value_to_Bus  = out_word[DATA_W-1:0];
  assign fire          = Enable_to_Bus && Ready_from_Bus;
  assign full_to_Host  = fifo_full;
  assign busy_to_Host  = !fifo_empty || (state == SEND);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and FIFO pop; flush overrides any pop or fire.
  always_comb begin
    state_nxt   = state;
    fifo_pop    = 1'b0;
    fifo_rd_clr = 1'b0;
    if (flush_from_Host) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            state_nxt = SEND;
          end
        end
        SEND: begin
          if (fire) begin
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
            end else begin
              fifo_rd_clr = 1'b1;
              state_nxt   = IDLE;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Sticky overflow: a push that found the FIFO full with no pop to make room.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_to_Host <= 1'b0;
    end else if (flush_from_Host) begin
      overflow_to_Host <= 1'b0;
    end else if (push_from_Host && fifo_full && !fifo_pop) begin
      overflow_to_Host <= 1'b1;
    end
  end

`ifdef MULTICAST_TX_STATS_EN
  // Saturating delivered-word and stalled-cycle counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sent_cnt_to_Host  <= '0;
      stall_cnt_to_Host <= '0;
    end else if (flush_from_Host) begin
      sent_cnt_to_Host  <= '0;
      stall_cnt_to_Host <= '0;
    end else begin
      if (fire && (sent_cnt_to_Host != '1))
        sent_cnt_to_Host <= sent_cnt_to_Host + 1'b1;
      if (Enable_to_Bus && !Ready_from_Bus && (stall_cnt_to_Host != '1))
        stall_cnt_to_Host <= stall_cnt_to_Host + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_multicast_tx.sv
// Scoreboard bench for multicast_tx: accepted pushes are queued, a
// negedge monitor pops and compares on every bus fire.
module tb_multicast_tx;
  localparam int TAG_W  = 6;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              push = 1'b0;
  logic [TAG_W-1:0]  tag_in = '0;
  logic [DATA_W-1:0] val_in = '0;
  logic              flush = 1'b0;
  logic              ready = 1'b0;
  logic              full, overflow, busy, en;
  logic [TAG_W-1:0]  tag_out;
  logic [DATA_W-1:0] val_out;
`ifdef MULTICAST_TX_STATS_EN
  logic [31:0]       sent_cnt, stall_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [TAG_W+DATA_W-1:0] sb[$];

  multicast_tx #(.DEPTH(8), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .push_from_Host   (push),
    .Tag_from_Host    (tag_in),
    .value_from_Host  (val_in),
    .flush_from_Host  (flush),
    .full_to_Host     (full),
    .overflow_to_Host (overflow),
    .busy_to_Host     (busy),
`ifdef MULTICAST_TX_STATS_EN
    .sent_cnt_to_Host (sent_cnt),
    .stall_cnt_to_Host(stall_cnt),
`endif
    .Ready_from_Bus   (ready),
    .Enable_to_Bus    (en),
    .Tag_to_Bus       (tag_out),
    .value_to_Bus     (val_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_w(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] v, input bit accept);
    push   = 1'b1;
    tag_in = t;
    val_in = v;
    if (accept) sb.push_back({t, v});
    tick();
    push = 1'b0;
  endtask

  // Monitor: every fire must deliver the oldest outstanding accepted word.
  always @(negedge clk) begin
    if (!rst && en && ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL bus_word: got tag %0h value %0h expected no word", tag_out, val_out);
      end else begin
        logic [TAG_W+DATA_W-1:0] exp_w;
        exp_w = sb.pop_front();
        if ({tag_out, val_out} !== exp_w) begin
          errors++;
          $display("FAIL bus_word: got tag %0h value %0h expected tag %0h value %0h",
                   tag_out, val_out, exp_w[DATA_W +: TAG_W], exp_w[DATA_W-1:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (2) tick();
    chk("rst_en", en, 0);
    chk("rst_tag", tag_out, 0);
    chk("rst_val", val_out, 0);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    tick();

    // Single word, two-cycle latency.
    ready = 1'b1;
    push_w(6'd5, 32'hDEADBEEF, 1);
    chk("t1_en_e1", en, 0);
    chk("t1_busy_e1", busy, 1);
    tick();
    chk("t1_en_e2", en, 1);
    chk("t1_tag_e2", tag_out, 5);
    chk("t1_val_e2", val_out, 32'hDEADBEEF);
    tick();
    chk("t1_en_e3", en, 0);
    chk("t1_busy_e3", busy, 0);
    chk("t1_tag_e3", tag_out, 0);

    // Four back-to-back words, no gaps.
    push_w(6'd1, 32'h11, 1);
    chk("t2_en0", en, 0);
    push_w(6'd2, 32'h22, 1);
    chk("t2_en1", en, 1);
    push_w(6'd3, 32'h33, 1);
    chk("t2_en2", en, 1);
    push_w(6'd4, 32'h44, 1);
    chk("t2_en3", en, 1);
    tick();
    chk("t2_en4", en, 1);
    chk("t2_tag4", tag_out, 4);
    tick();
    chk("t2_en5", en, 0);

    // Stall for five cycles, then deliver.
    ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    push_w(6'd9, 32'h12345678, 1);
    tick();
    chk("t3_en", en, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_hold_en", en, 1);
      chk("t3_hold_tag", tag_out, 9);
      chk("t3_hold_val", val_out, 32'h12345678);
    end
    ready = 1'b1;
    tick();
    chk("t3_en_done", en, 0);
`ifdef MULTICAST_TX_STATS_EN
    chk("t3_sent", sent_cnt, 1);
    chk("t3_stall", stall_cnt, 5);
`endif

    // Fill: one word in the output register plus eight buffered.
    ready = 1'b0;
    for (int i = 0; i < 9; i++) push_w(6'(10 + i), 32'h1000_0000 + 32'(i), 1);
    chk("t4_full", full, 1);
    chk("t4_ovf", overflow, 0);
    chk("t4_en", en, 1);
    chk("t4_tag", tag_out, 10);

    // Push into full FIFO while the head fires: accepted.
    ready = 1'b1;
    push_w(6'd19, 32'h1900, 1);
    chk("t5_full", full, 1);
    chk("t5_ovf", overflow, 0);
    chk("t5_tag", tag_out, 11);
    // Push into full FIFO with no fire: dropped.
    ready = 1'b0;
    push_w(6'd20, 32'h2000, 0);
    chk("t5_ovf_set", overflow, 1);
    chk("t5_full2", full, 1);
    ready = 1'b1;
    repeat (12) tick();
    chk("t5_drain_en", en, 0);
    chk("t5_drain_busy", busy, 0);
    chk("t5_ovf_sticky", overflow, 1);
    chk("t5_sb_empty", sb.size(), 0);

    // Flush mid-stream with a simultaneous push.
    ready = 1'b0;
    push_w(6'd30, 32'h30, 1);
    push_w(6'd31, 32'h31, 1);
    push_w(6'd32, 32'h32, 1);
    chk("t6_en_pre", en, 1);
    ready  = 1'b1;
    flush  = 1'b1;
    push   = 1'b1;
    tag_in = 6'd34;
    val_in = 32'h34;
    tick();
    flush = 1'b0;
    push  = 1'b0;
    chk("t6_sb_left", sb.size(), 2);
    sb.delete();
    chk("t6_en", en, 0);
    chk("t6_busy", busy, 0);
    chk("t6_full", full, 0);
    chk("t6_ovf_clr", overflow, 0);
    chk("t6_tag", tag_out, 0);
    repeat (2) tick();
    chk("t6_en_quiet", en, 0);
    push_w(6'd7, 32'h77, 1);
    chk("t6_en_e1", en, 0);
    tick();
    chk("t6_en_e2", en, 1);
    chk("t6_tag7", tag_out, 7);
    tick();
    chk("t6_en_e3", en, 0);
`ifdef MULTICAST_TX_STATS_EN
    chk("t6_sent", sent_cnt, 1);
    chk("t6_stall", stall_cnt, 0);
`endif
    chk("end_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
